// File: rtl/mem_arbiter_if.sv
// Requester, completion and memory-bus signals of the two-port memory arbiter.
// slave is the arbiter's view; master is the environment (datapath plus memory).
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_ic_req;
  logic [XLEN-1:0] i_ic_addr;
  logic [XLEN-1:0] o_ic_data;
  logic            o_ic_ready;

  logic            i_dm_rd;
  logic            i_dm_wen;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wd;
  logic [3:0]      i_dm_byte_en;
  logic [XLEN-1:0] o_dm_rdata;
  logic            o_dm_ready;

  logic            o_mem_req;
  logic            o_mem_we;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wd;
  logic [3:0]      o_mem_be;
  logic [XLEN-1:0] i_mem_rdata;
  logic            i_mem_ack;

  modport slave (
    input  i_ic_req, i_ic_addr, i_dm_rd, i_dm_wen, i_dm_addr, i_dm_wd, i_dm_byte_en,
           i_mem_rdata, i_mem_ack,
    output o_ic_data, o_ic_ready, o_dm_rdata, o_dm_ready,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wd, o_mem_be
  );

  modport master (
    output i_ic_req, i_ic_addr, i_dm_rd, i_dm_wen, i_dm_addr, i_dm_wd, i_dm_byte_en,
           i_mem_rdata, i_mem_ack,
    input  o_ic_data, o_ic_ready, o_dm_rdata, o_dm_ready,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wd, o_mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises I-fetch and data requests onto one single-port memory bus, one transaction at a time.
// Bus request one cycle after a requester asserts; ready pulses one cycle after i_mem_ack.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  io_bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_I = 2'd1,
    S_WAIT_D = 2'd2
  } state_t;

  localparam logic LP_DPRI = D_PRIORITY;

  state_t          r_state,      w_state_nxt;
  logic            r_last_d,     w_last_d_nxt;
  logic            r_mem_req,    w_mem_req_nxt;
  logic            r_mem_we,     w_mem_we_nxt;
  logic [XLEN-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [XLEN-1:0] r_mem_wd,     w_mem_wd_nxt;
  logic [3:0]      r_mem_be,     w_mem_be_nxt;
  logic [XLEN-1:0] r_ic_data,    w_ic_data_nxt;
  logic            r_ic_ready,   w_ic_ready_nxt;
  logic [XLEN-1:0] r_dm_rdata,   w_dm_rdata_nxt;
  logic            r_dm_ready,   w_dm_ready_nxt;

  logic w_ic_elig;
  logic w_dm_elig;
  logic w_pick_d;

  // A port whose ready is high this cycle is still showing last transaction's request.
  assign w_ic_elig = io_bus.i_ic_req & ~r_ic_ready;
  assign w_dm_elig = (io_bus.i_dm_rd | io_bus.i_dm_wen) & ~r_dm_ready;
  assign w_pick_d  = w_dm_elig & (~w_ic_elig | LP_DPRI | ~r_last_d);

  always_comb begin
    w_state_nxt    = r_state;
    w_last_d_nxt   = r_last_d;
    w_mem_req_nxt  = r_mem_req;
    w_mem_we_nxt   = r_mem_we;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_wd_nxt   = r_mem_wd;
    w_mem_be_nxt   = r_mem_be;
    w_ic_data_nxt  = r_ic_data;
    w_ic_ready_nxt = 1'b0;
    w_dm_rdata_nxt = r_dm_rdata;
    w_dm_ready_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ic_elig || w_dm_elig) begin
          w_mem_req_nxt = 1'b1;
          w_last_d_nxt  = w_pick_d;
          if (w_pick_d) begin
            w_mem_we_nxt   = io_bus.i_dm_wen;
            w_mem_addr_nxt = io_bus.i_dm_addr;
            w_mem_wd_nxt   = io_bus.i_dm_wd;
            w_mem_be_nxt   = io_bus.i_dm_byte_en;
            w_state_nxt    = S_WAIT_D;
          end else begin
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = io_bus.i_ic_addr;
            w_mem_wd_nxt   = '0;
            w_mem_be_nxt   = 4'hF;
            w_state_nxt    = S_WAIT_I;
          end
        end
      end
      S_WAIT_I: begin
        if (io_bus.i_mem_ack) begin
          w_mem_req_nxt  = 1'b0;
          w_ic_ready_nxt = 1'b1;
          w_ic_data_nxt  = io_bus.i_mem_rdata;
          w_state_nxt    = S_IDLE;
        end
      end
      S_WAIT_D: begin
        if (io_bus.i_mem_ack) begin
          w_mem_req_nxt  = 1'b0;
          w_dm_ready_nxt = 1'b1;
          if (!r_mem_we) w_dm_rdata_nxt = io_bus.i_mem_rdata;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_last_d   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      r_mem_be   <= '0;
      r_ic_data  <= '0;
      r_ic_ready <= 1'b0;
      r_dm_rdata <= '0;
      r_dm_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_d   <= w_last_d_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_wd   <= w_mem_wd_nxt;
      r_mem_be   <= w_mem_be_nxt;
      r_ic_data  <= w_ic_data_nxt;
      r_ic_ready <= w_ic_ready_nxt;
      r_dm_rdata <= w_dm_rdata_nxt;
      r_dm_ready <= w_dm_ready_nxt;
    end
  end

  assign io_bus.o_mem_req  = r_mem_req;
  assign io_bus.o_mem_we   = r_mem_we;
  assign io_bus.o_mem_addr = r_mem_addr;
  assign io_bus.o_mem_wd   = r_mem_wd;
  assign io_bus.o_mem_be   = r_mem_be;
  assign io_bus.o_ic_data  = r_ic_data;
  assign io_bus.o_ic_ready = r_ic_ready;
  assign io_bus.o_dm_rdata = r_dm_rdata;
  assign io_bus.o_dm_ready = r_dm_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority and a round-robin instance share clock and reset.
// Expected bus transactions and completions are queued when driven and popped when observed.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32)) bus1 ();
  mem_arbiter_if #(.XLEN(32)) bus0 ();

  mem_arbiter #(.XLEN(32), .D_PRIORITY(1'b1)) u_dut1 (.i_clk(clk), .i_rst(rst_n), .io_bus(bus1.slave));
  mem_arbiter #(.XLEN(32), .D_PRIORITY(1'b0)) u_dut0 (.i_clk(clk), .i_rst(rst_n), .io_bus(bus0.slave));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } bus_t;
  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } cpl_t;

  bus_t bus_q[$];
  cpl_t cpl_q[$];
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    bus_t b;
    b.we = we; b.addr = addr; b.wd = wd; b.be = be;
    bus_q.push_back(b);
  endtask

  task automatic push_cpl(input logic is_d, input logic [31:0] data);
    cpl_t c;
    c.is_d = is_d; c.data = data;
    cpl_q.push_back(c);
  endtask

  task automatic idle_inputs();
    bus1.i_ic_req = 0; bus1.i_ic_addr = '0; bus1.i_dm_rd = 0; bus1.i_dm_wen = 0;
    bus1.i_dm_addr = '0; bus1.i_dm_wd = '0; bus1.i_dm_byte_en = '0;
    bus1.i_mem_rdata = '0; bus1.i_mem_ack = 0;
    bus0.i_ic_req = 0; bus0.i_ic_addr = '0; bus0.i_dm_rd = 0; bus0.i_dm_wen = 0;
    bus0.i_dm_addr = '0; bus0.i_dm_wd = '0; bus0.i_dm_byte_en = '0;
    bus0.i_mem_rdata = '0; bus0.i_mem_ack = 0;
  endtask

  task automatic test_reset();
    logic [164:0] got;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    got = {bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_wd, bus1.o_mem_be,
           bus1.o_ic_data, bus1.o_ic_ready, bus1.o_dm_rdata, bus1.o_dm_ready};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_outs1: got %h exp 0", got); end
    checks++;
    if ({bus0.o_mem_req, bus0.o_ic_ready, bus0.o_dm_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_outs0: got %b exp 000", {bus0.o_mem_req, bus0.o_ic_ready, bus0.o_dm_ready});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus1.o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_idle: mem_req got %b exp 0", bus1.o_mem_req); end
  endtask

  task automatic test_i_zero_wait();
    bus_t b;
    cpl_t c;
    bus1.i_ic_req = 1; bus1.i_ic_addr = 32'h100;
    push_bus(1'b0, 32'h100, 32'h0, 4'hF);
    step();
    b = bus_q.pop_front();
    checks++;
    if ({bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_wd, bus1.o_mem_be} !== {1'b1, b.we, b.addr, b.wd, b.be}) begin
      errors++; $display("FAIL i_bus: got req=%b we=%b addr=%h wd=%h be=%h exp req=1 we=%b addr=%h wd=%h be=%h",
        bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_wd, bus1.o_mem_be, b.we, b.addr, b.wd, b.be);
    end
    bus1.i_mem_ack = 1; bus1.i_mem_rdata = 32'h13;
    push_cpl(1'b0, 32'h13);
    step();
    bus1.i_mem_ack = 0;
    c = cpl_q.pop_front();
    checks++;
    if ({bus1.o_ic_ready, bus1.o_dm_ready, bus1.o_mem_req} !== {~c.is_d, c.is_d, 1'b0}) begin
      errors++; $display("FAIL i_ready: got ic=%b dm=%b req=%b exp ic=1 dm=0 req=0", bus1.o_ic_ready, bus1.o_dm_ready, bus1.o_mem_req);
    end
    checks++;
    if (bus1.o_ic_data !== c.data) begin errors++; $display("FAIL i_data: got %h exp %h", bus1.o_ic_data, c.data); end
    bus1.i_ic_req = 0;
    step();
    checks++;
    if ({bus1.o_ic_ready, bus1.o_mem_req} !== 2'b00) begin
      errors++; $display("FAIL i_pulse: got ready=%b req=%b exp 00", bus1.o_ic_ready, bus1.o_mem_req);
    end
  endtask

  task automatic test_priority_tie();
    bus_t b;
    cpl_t c;
    bus1.i_ic_req = 1; bus1.i_ic_addr = 32'h200;
    bus1.i_dm_rd = 1; bus1.i_dm_addr = 32'h3000; bus1.i_dm_wd = 32'h55; bus1.i_dm_byte_en = 4'hF;
    push_bus(1'b0, 32'h3000, 32'h55, 4'hF);
    push_bus(1'b0, 32'h200, 32'h0, 4'hF);
    step();
    b = bus_q.pop_front();
    checks++;
    if ({bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_wd, bus1.o_mem_be} !== {1'b1, b.we, b.addr, b.wd, b.be}) begin
      errors++; $display("FAIL tie_first_grant: got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h",
        bus1.o_mem_addr, bus1.o_mem_we, bus1.o_mem_wd, b.addr, b.we, b.wd);
    end
    bus1.i_mem_ack = 1; bus1.i_mem_rdata = 32'hCAFEF00D;
    push_cpl(1'b1, 32'hCAFEF00D);
    step();
    bus1.i_mem_ack = 0;
    c = cpl_q.pop_front();
    checks++;
    if ({bus1.o_dm_ready, bus1.o_ic_ready, bus1.o_mem_req} !== {c.is_d, ~c.is_d, 1'b0} || bus1.o_dm_rdata !== c.data) begin
      errors++; $display("FAIL tie_d_ready: got dm=%b ic=%b req=%b data=%h exp dm=1 ic=0 req=0 data=%h",
        bus1.o_dm_ready, bus1.o_ic_ready, bus1.o_mem_req, bus1.o_dm_rdata, c.data);
    end
    bus1.i_dm_rd = 0;
    step();
    b = bus_q.pop_front();
    checks++;
    if ({bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_wd, bus1.o_mem_be} !== {1'b1, b.we, b.addr, b.wd, b.be}) begin
      errors++; $display("FAIL tie_second_grant: got req=%b addr=%h be=%h exp req=1 addr=%h be=%h",
        bus1.o_mem_req, bus1.o_mem_addr, bus1.o_mem_be, b.addr, b.be);
    end
    bus1.i_mem_ack = 1; bus1.i_mem_rdata = 32'h0A0B0C0D;
    push_cpl(1'b0, 32'h0A0B0C0D);
    step();
    bus1.i_mem_ack = 0;
    c = cpl_q.pop_front();
    checks++;
    if (bus1.o_ic_ready !== 1'b1 || bus1.o_ic_data !== c.data) begin
      errors++; $display("FAIL tie_i_ready: got ready=%b data=%h exp ready=1 data=%h", bus1.o_ic_ready, bus1.o_ic_data, c.data);
    end
    bus1.i_ic_req = 0;
    step();
  endtask

  task automatic test_d_write_wait();
    bus_t b;
    cpl_t c;
    bus1.i_dm_wen = 1; bus1.i_dm_addr = 32'h2004; bus1.i_dm_wd = 32'hDEADBEEF; bus1.i_dm_byte_en = 4'h3;
    push_bus(1'b1, 32'h2004, 32'hDEADBEEF, 4'h3);
    step();
    b = bus_q.pop_front();
    for (int cyc = 1; cyc <= 4; cyc++) begin
      checks++;
      if ({bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_wd, bus1.o_mem_be, bus1.o_dm_ready} !==
          {1'b1, b.we, b.addr, b.wd, b.be, 1'b0}) begin
        errors++; $display("FAIL wr_hold_c%0d: got req=%b we=%b addr=%h wd=%h be=%h rdy=%b exp req=1 we=%b addr=%h wd=%h be=%h rdy=0",
          cyc, bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_wd, bus1.o_mem_be, bus1.o_dm_ready, b.we, b.addr, b.wd, b.be);
      end
      if (cyc == 4) begin
        bus1.i_mem_ack = 1; bus1.i_mem_rdata = 32'hBAD0BAD0;
        push_cpl(1'b1, 32'hCAFEF00D);
      end
      step();
    end
    bus1.i_mem_ack = 0;
    c = cpl_q.pop_front();
    checks++;
    if ({bus1.o_dm_ready, bus1.o_mem_req} !== 2'b10 || bus1.o_dm_rdata !== c.data) begin
      errors++; $display("FAIL wr_ready: got rdy=%b req=%b rdata=%h exp rdy=1 req=0 rdata=%h",
        bus1.o_dm_ready, bus1.o_mem_req, bus1.o_dm_rdata, c.data);
    end
    bus1.i_dm_wen = 0;
    step();
    checks++;
    if (bus1.o_dm_ready !== 1'b0) begin errors++; $display("FAIL wr_pulse: got %b exp 0", bus1.o_dm_ready); end
  endtask

  task automatic test_round_robin();
    bus_t b;
    cpl_t c;
    logic exp_d;
    bus0.i_ic_req = 1; bus0.i_ic_addr = 32'h400;
    bus0.i_dm_rd = 1; bus0.i_dm_addr = 32'h500; bus0.i_dm_wd = 32'h0; bus0.i_dm_byte_en = 4'hC;
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) push_bus(1'b0, 32'h500, 32'h0, 4'hC);
      else            push_bus(1'b0, 32'h400, 32'h0, 4'hF);
    end
    step();
    for (int n = 0; n < 4; n++) begin
      exp_d = (n % 2 == 0);
      b = bus_q.pop_front();
      checks++;
      if ({bus0.o_mem_req, bus0.o_mem_addr, bus0.o_mem_be} !== {1'b1, b.addr, b.be}) begin
        errors++; $display("FAIL rr_grant%0d: got req=%b addr=%h be=%h exp req=1 addr=%h be=%h",
          n, bus0.o_mem_req, bus0.o_mem_addr, bus0.o_mem_be, b.addr, b.be);
      end
      bus0.i_mem_ack = 1; bus0.i_mem_rdata = 32'h1000 + n;
      push_cpl(exp_d, 32'h1000 + n);
      step();
      bus0.i_mem_ack = 0;
      c = cpl_q.pop_front();
      checks++;
      if ({bus0.o_dm_ready, bus0.o_ic_ready} !== {c.is_d, ~c.is_d} ||
          (c.is_d ? bus0.o_dm_rdata : bus0.o_ic_data) !== c.data) begin
        errors++; $display("FAIL rr_ready%0d: got dm=%b ic=%b dmd=%h icd=%h exp dm=%b ic=%b data=%h",
          n, bus0.o_dm_ready, bus0.o_ic_ready, bus0.o_dm_rdata, bus0.o_ic_data, c.is_d, ~c.is_d, c.data);
      end
      if (n == 3) begin bus0.i_ic_req = 0; bus0.i_dm_rd = 0; end
      step();
      checks++;
      if ({bus0.o_dm_ready, bus0.o_ic_ready} !== 2'b00) begin
        errors++; $display("FAIL rr_pulse%0d: got dm=%b ic=%b exp 00", n, bus0.o_dm_ready, bus0.o_ic_ready);
      end
    end
    checks++;
    if (bus0.o_mem_req !== 1'b0) begin errors++; $display("FAIL rr_drain: mem_req got %b exp 0", bus0.o_mem_req); end
  endtask

  task automatic test_reset_mid();
    bus_t b;
    cpl_t c;
    logic [164:0] got;
    bus1.i_dm_wen = 1; bus1.i_dm_addr = 32'h600; bus1.i_dm_wd = 32'h77; bus1.i_dm_byte_en = 4'hF;
    step();
    checks++;
    if (bus1.o_mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b exp 1", bus1.o_mem_req); end
    #2 rst_n = 1'b0;
    #1;
    got = {bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_wd, bus1.o_mem_be,
           bus1.o_ic_data, bus1.o_ic_ready, bus1.o_dm_rdata, bus1.o_dm_ready};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL rst_mid_outs: got %h exp 0", got); end
    bus1.i_dm_wen = 0;
    #1 rst_n = 1'b1;
    step();
    bus1.i_mem_ack = 1; bus1.i_mem_rdata = 32'h12345678;
    step();
    bus1.i_mem_ack = 0;
    checks++;
    if ({bus1.o_dm_ready, bus1.o_ic_ready, bus1.o_mem_req} !== 3'b000 || bus1.o_dm_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_late_ack: got dm=%b ic=%b req=%b rdata=%h exp 000 rdata=0",
        bus1.o_dm_ready, bus1.o_ic_ready, bus1.o_mem_req, bus1.o_dm_rdata);
    end
    bus1.i_ic_req = 1; bus1.i_ic_addr = 32'h700;
    push_bus(1'b0, 32'h700, 32'h0, 4'hF);
    step();
    b = bus_q.pop_front();
    checks++;
    if ({bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr, bus1.o_mem_be} !== {1'b1, b.we, b.addr, b.be}) begin
      errors++; $display("FAIL rst_fresh_grant: got req=%b addr=%h exp req=1 addr=%h", bus1.o_mem_req, bus1.o_mem_addr, b.addr);
    end
    bus1.i_mem_ack = 1; bus1.i_mem_rdata = 32'h99;
    push_cpl(1'b0, 32'h99);
    step();
    bus1.i_mem_ack = 0;
    c = cpl_q.pop_front();
    checks++;
    if (bus1.o_ic_ready !== 1'b1 || bus1.o_ic_data !== c.data) begin
      errors++; $display("FAIL rst_fresh_ready: got ready=%b data=%h exp ready=1 data=%h", bus1.o_ic_ready, bus1.o_ic_data, c.data);
    end
    bus1.i_ic_req = 0;
    step();
  endtask

  task automatic test_spurious_ack();
    bus1.i_mem_ack = 1; bus1.i_mem_rdata = 32'hFFFF0000;
    step();
    bus1.i_mem_ack = 0;
    checks++;
    if ({bus1.o_ic_ready, bus1.o_dm_ready, bus1.o_mem_req} !== 3'b000 ||
        bus1.o_ic_data !== 32'h99 || bus1.o_dm_rdata !== 32'h0) begin
      errors++; $display("FAIL spur_ack: got ic=%b dm=%b req=%b icd=%h dmd=%h exp 000 icd=99 dmd=0",
        bus1.o_ic_ready, bus1.o_dm_ready, bus1.o_mem_req, bus1.o_ic_data, bus1.o_dm_rdata);
    end
    bus1.i_dm_rd = 1; bus1.i_dm_addr = 32'h800; bus1.i_dm_byte_en = 4'h1;
    step();
    checks++;
    if ({bus1.o_mem_req, bus1.o_mem_addr, bus1.o_mem_be} !== {1'b1, 32'h800, 4'h1}) begin
      errors++; $display("FAIL spur_then_grant: got req=%b addr=%h be=%h exp req=1 addr=800 be=1",
        bus1.o_mem_req, bus1.o_mem_addr, bus1.o_mem_be);
    end
    bus1.i_mem_ack = 1; bus1.i_mem_rdata = 32'h5A5A;
    step();
    bus1.i_mem_ack = 0; bus1.i_dm_rd = 0;
    checks++;
    if (bus1.o_dm_ready !== 1'b1 || bus1.o_dm_rdata !== 32'h5A5A) begin
      errors++; $display("FAIL spur_then_ready: got rdy=%b data=%h exp rdy=1 data=5a5a", bus1.o_dm_ready, bus1.o_dm_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_i_zero_wait();
    test_priority_tie();
    test_d_write_wait();
    test_round_robin();
    test_reset_mid();
    test_spurious_ack();
    checks++;
    if (bus_q.size() + cpl_q.size() != 0) begin
      errors++; $display("FAIL queues_drained: got %0d entries exp 0", bus_q.size() + cpl_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
